a2d_spi_intf: RTL and testbench

A2D_SPI_INTF -- requirements
Module: a2d_spi_intf

---
 rtl/a2d_spi_intf.sv | 155 +++++++++++++++
 tb/tb_a2d_spi_intf.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/a2d_spi_intf.sv
// Purpose: conversion responder for the motion controller and SPI master for an ADC128S-style A2D.
// Latency: strt_cnv sampled at edge 0 -> res valid and cnv_cmplt high after edge 1047 (two 522-clock SPI words).
// Backpressure: none; strt_cnv is accepted only while idle and is otherwise dropped.
// Ports:
//   clk, rst_n           system clock, asynchronous active-low reset
//   strt_cnv, chnnl      one-clock conversion request and the channel (0-7) to convert
//   cnv_cmplt, res       completion level and the 12-bit result of the last completed conversion
//   a2d_SS_n, SCLK,      SPI slave select (active low), serial clock (idles high),
//   MOSI, MISO           data to and from the ADC
module a2d_spi_intf (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        strt_cnv,
   input  logic [2:0]  chnnl,
   output logic        cnv_cmplt,
   output logic [11:0] res,
   output logic        a2d_SS_n,
   output logic        SCLK,
   output logic        MOSI,
   input  logic        MISO
);

   typedef enum logic [2:0] {IDLE, TX1, GAP, TX2, DONE} state_t;

   state_t      state;
   state_t      nxt_state;
   logic        tx_start;

   logic [4:0]  sclk_div;
   logic [4:0]  rise_cnt;
   logic [15:0] shft_reg;
   logic        miso_q;
   logic [2:0]  chnnl_lat;
   logic        acc;
   logic        gap_cnt;

   logic        in_tx;
   logic        tx_end;
   logic        accept;

   assign in_tx  = (state == TX1) || (state == TX2);
   // The 16th rise has happened and the back porch has run out: stop before SCLK would fall again.
   assign tx_end = in_tx && (sclk_div == 5'd31) && (rise_cnt == 5'd16);
   // acc marks the clock right after an accepted request; a second request then is still ignored.
   assign accept = (state == IDLE) && !acc && strt_cnv;

   assign a2d_SS_n = !in_tx;
   assign SCLK     = sclk_div[4];
   assign MOSI     = in_tx & shft_reg[15];

   //------------------------------------------------------------------
   // FSM
   //------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nxt_state;
      end
   end

   always_comb begin
      nxt_state = state;
      tx_start  = 1'b0;
      case (state)
         IDLE: begin
            if (acc) begin
               nxt_state = TX1;
               tx_start  = 1'b1;
            end
         end
         TX1: begin
            if (tx_end) nxt_state = GAP;
         end
         GAP: begin
            if (gap_cnt) begin
               nxt_state = TX2;
               tx_start  = 1'b1;
            end
         end
         TX2: begin
            if (tx_end) nxt_state = DONE;
         end
         DONE: begin
            nxt_state = IDLE;
         end
         default: begin
            nxt_state = IDLE;
         end
      endcase
   end

   //------------------------------------------------------------------
   // Request capture and inter-word gap
   //------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= 1'b0;
         chnnl_lat <= 3'd0;
         gap_cnt   <= 1'b0;
      end else begin
         acc     <= accept;
         gap_cnt <= (state == GAP) && !gap_cnt;
         if (accept) chnnl_lat <= chnnl;
      end
   end

   //------------------------------------------------------------------
   // SCLK divider, MISO capture and shift register
   //------------------------------------------------------------------
   // The divider sits at 22 whenever no word is in flight, so SCLK idles high
   // and every word starts with the same 10-clock front porch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_div <= 5'd22;
         rise_cnt <= 5'd0;
         shft_reg <= 16'h0000;
         miso_q   <= 1'b0;
      end else if (tx_start) begin
         sclk_div <= 5'd22;
         rise_cnt <= 5'd0;
         shft_reg <= {2'b00, chnnl_lat, 11'h000};
      end else if (tx_end) begin
         sclk_div <= 5'd22;
         rise_cnt <= 5'd0;
         shft_reg <= {shft_reg[14:0], miso_q};
      end else if (in_tx) begin
         sclk_div <= sclk_div + 5'd1;
         if (sclk_div == 5'd15) begin
            rise_cnt <= rise_cnt + 5'd1;
            miso_q   <= MISO;
         end
         // The first fall only ends the front porch; bit 15 must survive to the first rise.
         if ((sclk_div == 5'd31) && (rise_cnt != 5'd0)) begin
            shft_reg <= {shft_reg[14:0], miso_q};
         end
      end
   end

   //------------------------------------------------------------------
   // Result and completion flag; the first word's reply is never stored
   //------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnv_cmplt <= 1'b0;
         res       <= 12'h000;
      end else if ((state == TX2) && tx_end) begin
         cnv_cmplt <= 1'b1;
         res       <= {shft_reg[10:0], miso_q};
      end else if (accept) begin
         cnv_cmplt <= 1'b0;
      end
   end

endmodule

// File: tb/tb_a2d_spi_intf.sv
module tb_a2d_spi_intf;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        strt_cnv = 1'b0;
   logic [2:0]  chnnl = 3'd0;
   logic        cnv_cmplt;
   logic [11:0] res;
   logic        a2d_SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO = 1'b0;

   int total = 0;
   int bad   = 0;

   a2d_spi_intf dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .strt_cnv  (strt_cnv),
      .chnnl     (chnnl),
      .cnv_cmplt (cnv_cmplt),
      .res       (res),
      .a2d_SS_n  (a2d_SS_n),
      .SCLK      (SCLK),
      .MOSI      (MOSI),
      .MISO      (MISO)
   );

   always #5 clk = ~clk;

   // Conversion values the ADC model returns for each channel.
   function automatic logic [11:0] adc_val(input logic [2:0] c);
      case (c)
         3'd0:    return 12'h0F0;
         3'd1:    return 12'h3C1;
         3'd2:    return 12'h7E2;
         3'd3:    return 12'hA5C;
         3'd4:    return 12'h124;
         3'd5:    return 12'h555;
         3'd6:    return 12'h6B6;
         default: return 12'h807;
      endcase
   endfunction

   //------------------------------------------------------------------
   // ADC model: each word replies with the conversion of the channel
   // commanded in the previous word, 4 zeros then 12 bits MSB first.
   // MISO changes on SCLK falls; MOSI is captured on SCLK rises.
   //------------------------------------------------------------------
   bit          ovr = 1'b0;          // force 0xFFFF on the first word, 0x0123 on the second
   logic [15:0] cur = 16'h0000;
   logic [15:0] mword = 16'h0000;
   logic [2:0]  prev_chan = 3'd0;
   bit          tx_num = 1'b0;
   int          fcnt = 0;
   int          rcnt = 0;
   logic        ss_d = 1'b1;
   logic        sclk_d = 1'b1;
   int          rise_q[$];
   int          mosi_q[$];

   always @(a2d_SS_n or SCLK) begin
      if (a2d_SS_n !== ss_d) begin
         if (a2d_SS_n === 1'b0) begin
            if (ovr) cur = (tx_num == 1'b0) ? 16'hFFFF : 16'h0123;
            else     cur = {4'h0, adc_val(prev_chan)};
            fcnt  = 0;
            rcnt  = 0;
            mword = 16'h0000;
            MISO  = cur[15];
         end else begin
            if (rst_n === 1'b1) begin
               rise_q.push_back(rcnt);
               mosi_q.push_back(int'(mword));
               prev_chan = mword[13:11];
               tx_num    = ~tx_num;
            end else begin
               tx_num = 1'b0;
            end
            MISO = 1'b0;
         end
      end else if ((a2d_SS_n === 1'b0) && (SCLK !== sclk_d)) begin
         if (SCLK === 1'b1) begin
            rcnt++;
            mword = {mword[14:0], MOSI};
         end else begin
            fcnt++;
            if (fcnt <= 16) MISO = cur[16 - fcnt];
         end
      end
      ss_d   = a2d_SS_n;
      sclk_d = SCLK;
   end

   //------------------------------------------------------------------
   // Slave-select run lengths and SCLK-idle monitor, sampled 2ns after clk rise
   //------------------------------------------------------------------
   int   lo_q[$];
   int   hi_q[$];
   int   run = 0;
   logic prev_ss = 1'b1;
   int   viol = 0;

   always @(posedge clk) begin
      #2;
      if (rst_n !== 1'b1) begin
         run     = 0;
         prev_ss = a2d_SS_n;
      end else if (a2d_SS_n !== prev_ss) begin
         if (prev_ss === 1'b0) lo_q.push_back(run);
         else                  hi_q.push_back(run);
         run     = 1;
         prev_ss = a2d_SS_n;
      end else begin
         run++;
      end
      if ((a2d_SS_n === 1'b1) && (SCLK !== 1'b1)) viol++;
   end

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Runs one conversion starting from a negedge. early=1 also raises strt_cnv
   // in the current clock (the DONE clock of the previous conversion), which must be ignored.
   // interfere=1 issues extra requests with chnnl=7 at clocks 100 and 600.
   task automatic conv(input logic [2:0] ch, input bit interfere, input bit early,
                       input logic [11:0] exp_res);
      int lat;
      int blo;
      int bhi;
      int btx;
      logic [15:0] cmd;
      cmd = {2'b00, ch, 11'h000};
      blo = lo_q.size();
      bhi = hi_q.size();
      btx = rise_q.size();
      strt_cnv = early;
      chnnl    = ch;
      @(negedge clk);
      strt_cnv = 1'b1;
      @(negedge clk);
      strt_cnv = 1'b0;
      chk("cmplt_cleared", cnv_cmplt, 0);
      lat = 0;
      while ((cnv_cmplt !== 1'b1) && (lat < 1200)) begin
         @(negedge clk);
         lat++;
         if (interfere && (lat == 100)) begin
            strt_cnv = 1'b1;
            chnnl    = 3'd7;
         end else if (interfere && (lat == 600)) begin
            strt_cnv = 1'b1;
         end else begin
            strt_cnv = 1'b0;
         end
      end
      strt_cnv = 1'b0;
      chk("latency", lat, 1047);
      chk("res", res, exp_res);
      chk("ss_low_tx1", qget(lo_q, blo), 522);
      chk("ss_low_tx2", qget(lo_q, blo + 1), 522);
      chk("ss_high_gap", qget(hi_q, bhi + 1), 2);
      chk("sclk_rises_tx1", qget(rise_q, btx), 16);
      chk("sclk_rises_tx2", qget(rise_q, btx + 1), 16);
      chk("mosi_word_tx1", qget(mosi_q, btx), cmd);
      chk("mosi_word_tx2", qget(mosi_q, btx + 1), cmd);
      chk("sclk_high_when_ss_high", viol, 0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_ss_n", a2d_SS_n, 1);
      chk("rst_sclk", SCLK, 1);
      chk("rst_mosi", MOSI, 0);
      chk("rst_cmplt", cnv_cmplt, 0);
      chk("rst_res", res, 12'h000);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Basic conversion of channel 3
      conv(3'd3, 1'b0, 1'b0, 12'hA5C);

      // Requests during a conversion, with chnnl switched to 7, are ignored
      conv(3'd3, 1'b1, 1'b0, 12'hA5C);

      // Back-to-back conversions; a request in the DONE clock is ignored
      conv(3'd0, 1'b0, 1'b1, 12'h0F0);
      conv(3'd1, 1'b0, 1'b1, 12'h3C1);
      conv(3'd4, 1'b0, 1'b1, 12'h124);
      conv(3'd3, 1'b0, 1'b1, 12'hA5C);
      conv(3'd2, 1'b0, 1'b1, 12'h7E2);
      conv(3'd7, 1'b0, 1'b1, 12'h807);

      // First-word reply is discarded
      ovr = 1'b1;
      conv(3'd6, 1'b0, 1'b0, 12'h123);
      ovr = 1'b0;

      // Reset in the middle of the second word
      @(negedge clk);
      strt_cnv = 1'b1;
      chnnl    = 3'd5;
      @(negedge clk);
      strt_cnv = 1'b0;
      repeat (825) @(negedge clk);
      chk("abort_in_tx2", a2d_SS_n, 0);
      chk("res_held_mid_tx2", res, 12'h123);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_ss_n", a2d_SS_n, 1);
      chk("abort_sclk", SCLK, 1);
      chk("abort_mosi", MOSI, 0);
      chk("abort_cmplt", cnv_cmplt, 0);
      chk("abort_res", res, 12'h000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_abort_res", res, 12'h000);
      conv(3'd0, 1'b0, 1'b0, 12'h0F0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
